// File: rtl/cp0_ctrl_pkg.sv
// Shared definitions for the CP0 controller: register numbers, Status/Cause
// bit positions, write masks, exception codes, exc_vec_i bit indices and
// exception vector addresses, plus the winner-to-ExcCode mapping.
package cp0_ctrl_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;

  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

  localparam int EXV_ADEL_IF = 0;
  localparam int EXV_RI      = 1;
  localparam int EXV_SYS     = 2;
  localparam int EXV_BP      = 3;
  localparam int EXV_OV      = 4;
  localparam int EXV_ADEL_LD = 5;
  localparam int EXV_ADES    = 6;
  localparam int EXV_ERET    = 7;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] VEC_BEV     = 32'hbfc0_0380;
  localparam logic [31:0] VEC_NORM    = 32'h8000_0180;
  localparam logic [31:0] EBASE_RST   = 32'h8000_0000;
  localparam logic [31:0] EBASE_WMASK = 32'h3fff_f000;

  typedef enum logic [3:0] {
    SRC_NONE,
    SRC_INT,
    SRC_ADEL_IF,
    SRC_RI,
    SRC_SYS,
    SRC_BP,
    SRC_OV,
    SRC_ADEL_LD,
    SRC_ADES,
    SRC_ERET
  } exc_src_e;

  function automatic logic [4:0] exc_code(input exc_src_e src);
    case (src)
      SRC_ADEL_IF, SRC_ADEL_LD: exc_code = EXC_ADEL;
      SRC_ADES:                 exc_code = EXC_ADES;
      SRC_SYS:                  exc_code = EXC_SYS;
      SRC_BP:                   exc_code = EXC_BP;
      SRC_RI:                   exc_code = EXC_RI;
      SRC_OV:                   exc_code = EXC_OV;
      default:                  exc_code = EXC_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: prescaler, Count, Compare and the latched timer interrupt.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   count_we          committed mtc0 to Count (beats the increment, clears prescaler)
//   compare_we        committed mtc0 to Compare (beats a same-cycle match, clears timer_int)
//   wdata             mtc0 data
//   count, compare    current register values
//   timer_int         set on Count==Compare with Compare!=0, held until a Compare write
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      count     <= '0;
      compare   <= '0;
      timer_int <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        presc <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) count <= count + 32'd1;
      end

      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 for the MEM stage: Status/Cause/EPC/BadVAddr/Count/Compare/PRId/Config,
// interrupt sampling and masking, exception priority encoding, and the
// flush / redirect PC for exceptions and ERET.
// Optional feature macro: CP0_EBASE_EN adds EBase (reg 15 sel 1) on a
// sel_i port and makes the non-BEV vector {EBase[31:12],12'h180}.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ext_int               level hw interrupts -> Cause.IP2 upward
//   stallW                commit stalled: no exc/mtc0 state update
//   exc_vec_i             MEM exception flags (ADEL_IF..ERET)
//   pc_i, in_ds_i         MEM PC and delay-slot flag
//   badvaddr_i            faulting load/store address
//   we_i/waddr_i/wdata_i  mtc0
//   raddr_i/rdata_o       mfc0 (combinational, no bypass)
//   sel_i                 register select (CP0_EBASE_EN only)
//   flush_o, new_pc_o     exception/ERET redirect
//   status_o/cause_o/epc_o
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] ext_int,
  input  logic                  stallW,
  input  logic [7:0]            exc_vec_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_ds_i,
  input  logic [31:0]           badvaddr_i,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
`ifdef CP0_EBASE_EN
  input  logic [2:0]            sel_i,
`endif
  output logic [31:0]           rdata_o,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  logic [31:0] status_q;
  logic [4:0]  exc_code_q;
  logic        bd_q;
  logic [1:0]  ip_sw_q;
  logic [5:0]  ip_hw_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_int;
  logic [7:0]  ip;
  logic        int_req;
  exc_src_e    src;
  logic        take;
  logic        exc_taken;
  logic        mtc0_en;
  logic [31:0] exc_vector;

`ifdef CP0_EBASE_EN
  logic [31:0] ebase_q;
`endif

  // Timer interrupt shares IP7 with the top hw line.
  assign ip       = {ip_hw_q[5] | timer_int, ip_hw_q[4:0], ip_sw_q};
  assign status_o = status_q;
  assign cause_o  = {bd_q, timer_int, 14'd0, ip, 1'b0, exc_code_q, 2'b00};
  assign epc_o    = epc_q;

  assign int_req = status_q[ST_IE] & ~status_q[ST_EXL] & (|(ip & status_q[15:8]));

  always_comb begin
    src = SRC_NONE;
    if (int_req)                     src = SRC_INT;
    else if (exc_vec_i[EXV_ADEL_IF]) src = SRC_ADEL_IF;
    else if (exc_vec_i[EXV_RI])      src = SRC_RI;
    else if (exc_vec_i[EXV_SYS])     src = SRC_SYS;
    else if (exc_vec_i[EXV_BP])      src = SRC_BP;
    else if (exc_vec_i[EXV_OV])      src = SRC_OV;
    else if (exc_vec_i[EXV_ADEL_LD]) src = SRC_ADEL_LD;
    else if (exc_vec_i[EXV_ADES])    src = SRC_ADES;
    else if (exc_vec_i[EXV_ERET])    src = SRC_ERET;
  end

  assign take      = (src != SRC_NONE) & ~stallW;
  assign exc_taken = take & (src != SRC_ERET);
  // mtc0 loses to any redirect in the same cycle.
  assign mtc0_en   = we_i & ~stallW & ~take;

`ifdef CP0_EBASE_EN
  assign exc_vector = status_q[22] ? VEC_BEV : {ebase_q[31:12], 12'h180};
`else
  assign exc_vector = status_q[22] ? VEC_BEV : VEC_NORM;
`endif

  assign flush_o  = take;
  // ERET redirects to the registered EPC; a same-cycle mtc0 EPC is not seen.
  assign new_pc_o = (src == SRC_ERET) ? epc_q : exc_vector;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0_en && (waddr_i == REG_COUNT)),
    .compare_we (mtc0_en && (waddr_i == REG_COMPARE)),
    .wdata      (wdata_i),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      exc_code_q <= '0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
`ifdef CP0_EBASE_EN
      ebase_q    <= EBASE_RST;
`endif
    end else begin
      // Hardware lines are sampled even while the pipeline is stalled.
      ip_hw_q <= 6'(ext_int);

      if (exc_taken) begin
        // Nested exceptions keep the original EPC/BD.
        if (!status_q[ST_EXL]) begin
          epc_q <= in_ds_i ? (pc_i - 32'd4) : pc_i;
          bd_q  <= in_ds_i;
        end
        status_q[ST_EXL] <= 1'b1;
        exc_code_q       <= exc_code(src);
        case (src)
          SRC_ADEL_IF:           badvaddr_q <= pc_i;
          SRC_ADEL_LD, SRC_ADES: badvaddr_q <= badvaddr_i;
          default: ;
        endcase
      end else if (take) begin
        status_q[ST_EXL] <= 1'b0;
      end else if (mtc0_en) begin
        case (waddr_i)
          REG_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
          REG_CAUSE:  ip_sw_q  <= wdata_i[9:8];
          REG_EPC:    epc_q    <= wdata_i;
`ifdef CP0_EBASE_EN
          REG_PRID: begin
            if (sel_i == 3'd1) ebase_q <= (ebase_q & ~EBASE_WMASK) | (wdata_i & EBASE_WMASK);
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if (!rst) begin
      case (raddr_i)
        REG_BADVADDR: rdata_o = badvaddr_q;
        REG_COUNT:    rdata_o = count;
        REG_COMPARE:  rdata_o = compare;
        REG_STATUS:   rdata_o = status_o;
        REG_CAUSE:    rdata_o = cause_o;
        REG_EPC:      rdata_o = epc_q;
`ifdef CP0_EBASE_EN
        REG_PRID:     rdata_o = (sel_i == 3'd1) ? ebase_q : PRID_VAL;
`else
        REG_PRID:     rdata_o = PRID_VAL;
`endif
        REG_CONFIG:   rdata_o = CONFIG_VAL;
        default:      rdata_o = '0;
      endcase
    end
  end

endmodule
